piano_voice_allocator: RTL and testbench

Polyphony controller that sits between the keyboard input (one level per key) and a bank of `N_VOICES` `piano_note` voice generators. It detects key press/release edges, queues them, and assigns each pressed key to a voice. When all voices are busy it steals the oldest one. Per voice it drives the `key_press`, note index and octave inputs of the generators; the generator outputs are mixed elsewhere.

---
 rtl/piano_voice_allocator.sv | 156 +++++++++++++++
 tb/tb_piano_voice_allocator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/piano_voice_allocator.sv
// Polyphony controller: turns key level changes into queued press/release events
// and assigns pressed keys to a bank of voice generators, stealing the oldest when full.
module piano_voice_allocator #(
  parameter int N_KEYS   = 12,
  parameter int N_VOICES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_KEYS-1:0]     key_down,
  input  logic [2:0]            octave_in,
  output logic [N_VOICES-1:0]   voice_active,
  output logic [4*N_VOICES-1:0] voice_key,
  output logic [3*N_VOICES-1:0] voice_octave,
  output logic                  steal_pulse,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, REL, ALLOC} state_t;

  localparam logic [2:0] AGE_MAX = 3'(N_VOICES - 1);

  state_t              state, state_next;
  logic [N_KEYS-1:0]   key_q, rise, fall;
  logic [N_KEYS-1:0]   pend_press, pend_rel, clr_press, clr_rel;
  logic [3:0]          idx, pick_rel, pick_press;
  logic [3:0]          key_r [N_VOICES];
  logic [2:0]          oct_r [N_VOICES];
  logic [2:0]          age   [N_VOICES];
  logic                hit, free_found;
  logic [2:0]          free_sel, steal_sel, sel, max_age;

  function automatic logic [3:0] lowest(input logic [N_KEYS-1:0] m);
    lowest = '0;
    for (int i = N_KEYS - 1; i >= 0; i--)
      if (m[i]) lowest = 4'(i);
  endfunction

  assign rise       = key_down & ~key_q;
  assign fall       = ~key_down & key_q;
  assign pick_rel   = lowest(pend_rel);
  assign pick_press = lowest(pend_press);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (|pend_rel) state_next = REL;
                  else if (|pend_press) state_next = ALLOC;
      REL, ALLOC: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_rel   = '0;
    clr_press = '0;
    if (state == IDLE) begin
      for (int i = 0; i < N_KEYS; i++) begin
        clr_rel[i]   = (|pend_rel) && (pick_rel == 4'(i));
        clr_press[i] = !(|pend_rel) && (|pend_press) && (pick_press == 4'(i));
      end
    end
    busy = (state != IDLE) || (|pend_press) || (|pend_rel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q      <= '0;
      pend_press <= '0;
      pend_rel   <= '0;
      idx        <= '0;
    end else begin
      key_q      <= key_down;
      // NOTE: set terms are applied after the FSM clear so a same-cycle event on the consumed key survives.
      pend_press <= ((pend_press & ~clr_press) | rise) & ~fall;
      pend_rel   <= (pend_rel & ~clr_rel) | fall;
      if (state == IDLE) begin
        if (|pend_rel)        idx <= pick_rel;
        else if (|pend_press) idx <= pick_press;
      end
    end
  end

  // Allocation choice: existing holder, else lowest free voice, else oldest (lowest index on tie).
  always_comb begin
    hit        = 1'b0;
    free_found = 1'b0;
    free_sel   = '0;
    steal_sel  = '0;
    max_age    = age[0];
    for (int v = 0; v < N_VOICES; v++)
      if (voice_active[v] && key_r[v] == idx) hit = 1'b1;
    for (int v = N_VOICES - 1; v >= 0; v--)
      if (!voice_active[v]) begin
        free_found = 1'b1;
        free_sel   = 3'(v);
      end
    for (int v = 1; v < N_VOICES; v++)
      if (age[v] > max_age) begin
        max_age   = age[v];
        steal_sel = 3'(v);
      end
    sel = free_found ? free_sel : steal_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      voice_active <= '0;
      steal_pulse  <= 1'b0;
      for (int v = 0; v < N_VOICES; v++) begin
        key_r[v] <= '0;
        oct_r[v] <= '0;
        age[v]   <= '0;
      end
    end else begin
      steal_pulse <= 1'b0;
      case (state)
        REL: begin
          for (int v = 0; v < N_VOICES; v++)
            if (voice_active[v] && key_r[v] == idx) voice_active[v] <= 1'b0;
        end
        ALLOC: begin
          if (hit) begin
            for (int v = 0; v < N_VOICES; v++)
              if (voice_active[v] && key_r[v] == idx) age[v] <= '0;
          end else begin
            steal_pulse <= !free_found;
            for (int v = 0; v < N_VOICES; v++) begin
              if (3'(v) == sel) begin
                voice_active[v] <= 1'b1;
                key_r[v]        <= idx;
                oct_r[v]        <= octave_in;
                age[v]          <= '0;
              end else if (voice_active[v] && age[v] != AGE_MAX) begin
                age[v] <= age[v] + 3'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int v = 0; v < N_VOICES; v++) begin
      voice_key[4*v +: 4]    = key_r[v];
      voice_octave[3*v +: 3] = oct_r[v];
    end
  end

endmodule

// File: tb/tb_piano_voice_allocator.sv
// Directed bench for piano_voice_allocator: allocation, stealing, queued events,
// release priority, short taps and reset in mid-operation, with hand-computed expectations.
module tb_piano_voice_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] key_down;
  logic [2:0]  octave_in;
  logic [3:0]  voice_active;
  logic [15:0] voice_key;
  logic [11:0] voice_octave;
  logic        steal_pulse;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  piano_voice_allocator #(.N_KEYS(12), .N_VOICES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_down     (key_down),
    .octave_in    (octave_in),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .voice_octave (voice_octave),
    .steal_pulse  (steal_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    key_down = '0;
    reset    = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    key_down  = '0;
    octave_in = '0;
    reset     = 1'b1;
    step();
    step();
    check("rst_active", voice_active, 4'b0000);
    check("rst_key", voice_key, 16'h0000);
    check("rst_oct", voice_octave, 12'h000);
    check("rst_steal", steal_pulse, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();

    // Basic allocation and release of key 3
    key_down[3] = 1'b1;
    octave_in   = 3'd2;
    step();
    check("t1_busy", busy, 1'b1);
    step();
    check("t1_lat1", voice_active, 4'b0000);
    step();
    check("t1_active", voice_active, 4'b0001);
    check("t1_key", voice_key[3:0], 4'd3);
    check("t1_oct", voice_octave[2:0], 3'd2);
    key_down[3] = 1'b0;
    step();
    step();
    check("t1_rel_lat1", voice_active, 4'b0001);
    step();
    check("t1_rel", voice_active, 4'b0000);
    check("t1_rel_keep", voice_key[3:0], 4'd3);

    // Fill all voices, then steal the oldest
    key_down[0] = 1'b1; octave_in = 3'd1; step(); step(); step();
    key_down[1] = 1'b1; octave_in = 3'd3; step(); step(); step();
    key_down[2] = 1'b1; octave_in = 3'd4; step(); step(); step();
    key_down[3] = 1'b1; octave_in = 3'd6; step(); step(); step();
    check("t2_full", voice_active, 4'b1111);
    check("t2_keys", voice_key, 16'h3210);
    key_down[5] = 1'b1;
    octave_in   = 3'd5;
    step();
    step();
    check("t2_steal_early", steal_pulse, 1'b0);
    step();
    check("t2_steal", steal_pulse, 1'b1);
    check("t2_keys5", voice_key, 16'h3215);
    check("t2_octs", voice_octave, {3'd6, 3'd4, 3'd3, 3'd5});
    step();
    check("t2_steal_end", steal_pulse, 1'b0);
    key_down[8] = 1'b1;
    octave_in   = 3'd0;
    step(); step(); step();
    check("t2_steal2", steal_pulse, 1'b1);
    check("t2_keys8", voice_key, 16'h3285);

    // Simultaneous presses are served lowest key first
    apply_reset();
    key_down  = 12'b0000_1001_0010;
    octave_in = 3'd3;
    step();
    step(); step();
    check("t3_a1", voice_active, 4'b0001);
    check("t3_k1", voice_key[3:0], 4'd1);
    step(); step();
    check("t3_a2", voice_active, 4'b0011);
    step();
    check("t3_busy5", busy, 1'b1);
    step();
    check("t3_a3", voice_active, 4'b0111);
    check("t3_busy6", busy, 1'b0);
    check("t3_keys", voice_key, 16'h0741);
    key_down[10] = 1'b1;
    step(); step(); step();
    check("t3_full", voice_active, 4'b1111);
    check("t3_keysA", voice_key, 16'hA741);

    // Release has priority; the freed voice is reused without stealing
    key_down[4] = 1'b0;
    key_down[9] = 1'b1;
    step(); step(); step();
    check("t4_rel", voice_active, 4'b1101);
    step(); step();
    check("t4_realloc", voice_active, 4'b1111);
    check("t4_keys", voice_key, 16'hA791);
    check("t4_nosteal", steal_pulse, 1'b0);

    // Short tap on key 2 while the FSM is busy: never allocated
    key_down[10] = 1'b0;
    step();
    key_down[2] = 1'b1;
    step();
    key_down[2] = 1'b0;
    step();
    check("t5_rel10", voice_active, 4'b0111);
    step(); step();
    check("t5_idle", busy, 1'b0);
    step(); step(); step(); step();
    check("t5_no_alloc", voice_active, 4'b0111);

    // Re-press key 2 while its release is pending: release first, then allocate
    key_down[7] = 1'b0;
    step();
    key_down[2] = 1'b1;
    step();
    key_down[2] = 1'b0;
    step();
    key_down[2] = 1'b1;
    step(); step(); step();
    check("t5b_pre", voice_active, 4'b0011);
    step();
    check("t5b_alloc", voice_active, 4'b0111);
    check("t5b_keys", voice_key, 16'hA291);
    check("t5b_nosteal", steal_pulse, 1'b0);

    // Reset asserted while in ALLOC; held keys are reallocated afterwards
    key_down[0] = 1'b1;
    key_down[6] = 1'b1;
    octave_in   = 3'd7;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_active", voice_active, 4'b0000);
    check("t6_rst_key", voice_key, 16'h0000);
    check("t6_rst_busy", busy, 1'b0);
    key_down = 12'b0000_0100_0001;
    step();
    reset = 1'b0;
    step(); step(); step();
    check("t6_first", voice_active, 4'b0001);
    step(); step();
    check("t6_active", voice_active, 4'b0011);
    check("t6_keys", voice_key, 16'h0060);
    check("t6_octs", voice_octave, {3'd0, 3'd0, 3'd7, 3'd7});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
